// File: rtl/bkram_sd_ctrl.sv
// Backup-RAM sequencer: moves the save image between the dual-port BRAM and the HPS SD
// sector interface (load, save, autosave, auto-load after download) and writes the format header.
module bkram_sd_ctrl #(
   parameter int          SECTORS   = 16,
   parameter int          FMT_WORDS = 4,
   parameter logic [63:0] FMT_HDR   = 64'h8010_8800_4D42_5548
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        bk_ena,
   input  logic        load_req,
   input  logic        save_req,
   input  logic        autosave_en,
   input  logic        osd_open,
   input  logic        mount_load,
   input  logic        format_req,
   input  logic        bram_wr,
   input  logic        sd_ack,
   output logic [31:0] sd_lba,
   output logic        sd_rd,
   output logic        sd_wr,
   output logic        fmt_we,
   output logic [1:0]  fmt_addr,
   output logic [15:0] fmt_data,
   output logic        busy,
   output logic        loading,
   output logic        pending
);

   localparam int LBA_W = $clog2(SECTORS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_XFER = 2'd2,
      S_FMT  = 2'd3
   } state_t;

   state_t             state_r;
   logic [LBA_W-1:0]   lba_r;
   logic               is_load_r;
   logic               load_q_r;
   logic               save_q_r;
   logic               fmt_q_r;
   logic               auto_q_r;
   logic               ack_q_r;

   logic               auto_cond_s;
   logic               load_trig_s;
   logic               save_trig_s;
   logic               fmt_trig_s;
   logic               ack_rise_s;
   logic               ack_fall_s;
   logic               idle_s;
   logic               start_load_s;
   logic               start_save_s;
   logic               start_fmt_s;
   logic               last_sec_s;
   logic               load_done_s;
   logic               fmt_end_s;
   logic               pend_set_s;

   function automatic logic [15:0] fmt_word(input logic [1:0] idx);
      return FMT_HDR[{idx, 4'b0000} +: 16];
   endfunction

   // Autosave fires once on the rising edge of "dirty and OSD open"
   assign auto_cond_s  = pending & osd_open & autosave_en;
   assign load_trig_s  = bk_ena & ((load_req & ~load_q_r) | mount_load);
   assign save_trig_s  = bk_ena & ((save_req & ~save_q_r) | (auto_cond_s & ~auto_q_r));
   assign fmt_trig_s   = format_req & ~fmt_q_r;
   assign ack_rise_s   = sd_ack & ~ack_q_r;
   assign ack_fall_s   = ~sd_ack & ack_q_r;

   assign idle_s       = (state_r == S_IDLE);
   assign start_load_s = idle_s & load_trig_s;
   assign start_save_s = idle_s & ~load_trig_s & save_trig_s;
   assign start_fmt_s  = idle_s & ~load_trig_s & ~save_trig_s & fmt_trig_s;
   assign last_sec_s   = (lba_r == LBA_W'(SECTORS - 1));
   assign load_done_s  = (state_r == S_XFER) & ack_fall_s & last_sec_s & is_load_r;
   assign fmt_end_s    = (state_r == S_FMT) & (fmt_addr == 2'(FMT_WORDS - 1));
   assign pend_set_s   = (bram_wr & bk_ena & ~osd_open) | fmt_end_s;

   assign sd_lba       = {{(32 - LBA_W){1'b0}}, lba_r};

   // Edge-detect history for level requests, autosave condition and sector ack
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         load_q_r <= 1'b0;
         save_q_r <= 1'b0;
         fmt_q_r  <= 1'b0;
         auto_q_r <= 1'b0;
         ack_q_r  <= 1'b0;
      end else begin
         load_q_r <= load_req;
         save_q_r <= save_req;
         fmt_q_r  <= format_req;
         auto_q_r <= auto_cond_s;
         ack_q_r  <= sd_ack;
      end
   end

   // Transfer / format sequencer with registered request outputs
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= S_IDLE;
         lba_r     <= '0;
         is_load_r <= 1'b0;
         sd_rd     <= 1'b0;
         sd_wr     <= 1'b0;
         busy      <= 1'b0;
         loading   <= 1'b0;
         fmt_we    <= 1'b0;
         fmt_addr  <= 2'd0;
         fmt_data  <= 16'd0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start_load_s || start_save_s) begin
                  state_r   <= S_REQ;
                  busy      <= 1'b1;
                  lba_r     <= '0;
                  is_load_r <= start_load_s;
                  sd_rd     <= start_load_s;
                  sd_wr     <= start_save_s;
                  loading   <= start_load_s;
               end else if (start_fmt_s) begin
                  state_r  <= S_FMT;
                  busy     <= 1'b1;
                  fmt_we   <= 1'b1;
                  fmt_addr <= 2'd0;
                  fmt_data <= fmt_word(2'd0);
               end
            end
            S_REQ: begin
               if (ack_rise_s) begin
                  sd_rd   <= 1'b0;
                  sd_wr   <= 1'b0;
                  state_r <= S_XFER;
               end
            end
            S_XFER: begin
               if (ack_fall_s) begin
                  if (last_sec_s) begin
                     state_r <= S_IDLE;
                     busy    <= 1'b0;
                     loading <= 1'b0;
                  end else begin
                     lba_r   <= lba_r + LBA_W'(1);
                     sd_rd   <= is_load_r;
                     sd_wr   <= ~is_load_r;
                     state_r <= S_REQ;
                  end
               end
            end
            S_FMT: begin
               if (fmt_end_s) begin
                  fmt_we  <= 1'b0;
                  busy    <= 1'b0;
                  state_r <= S_IDLE;
               end else begin
                  fmt_addr <= fmt_addr + 2'd1;
                  fmt_data <= fmt_word(fmt_addr + 2'd1);
               end
            end
            default: begin
               state_r <= S_IDLE;
               sd_rd   <= 1'b0;
               sd_wr   <= 1'b0;
               busy    <= 1'b0;
               loading <= 1'b0;
               fmt_we  <= 1'b0;
            end
         endcase
      end
   end

   // Dirty flag: a set in the same cycle as a clear wins
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         pending <= 1'b0;
      end else if (pend_set_s) begin
         pending <= 1'b1;
      end else if (start_save_s || load_done_s) begin
         pending <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bkram_sd_ctrl.sv
// Scoreboard bench for bkram_sd_ctrl: an HPS ack responder, a stimulus process pushing
// expected sector/format/completion events, and a monitor comparing what the DUT presents.
module tb_bkram_sd_ctrl;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        bk_ena = 1'b0, load_req = 1'b0, save_req = 1'b0, autosave_en = 1'b0;
   logic        osd_open = 1'b0, mount_load = 1'b0, format_req = 1'b0, bram_wr = 1'b0;
   logic        sd_ack = 1'b0;
   logic [31:0] sd_lba;
   logic        sd_rd, sd_wr, fmt_we, busy, loading, pending;
   logic [1:0]  fmt_addr;
   logic [15:0] fmt_data;

   always #5 clk_sys = ~clk_sys;

   bkram_sd_ctrl dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .bk_ena(bk_ena), .load_req(load_req),
      .save_req(save_req), .autosave_en(autosave_en), .osd_open(osd_open),
      .mount_load(mount_load), .format_req(format_req), .bram_wr(bram_wr),
      .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
      .fmt_we(fmt_we), .fmt_addr(fmt_addr), .fmt_data(fmt_data), .busy(busy),
      .loading(loading), .pending(pending)
   );

   // kind 0 = sector request, 1 = format word, 2 = operation complete
   typedef struct {
      int          kind;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [15:0] data;
      logic        ld;
      logic        pd;
   } ev_t;

   ev_t         exp_q[$];
   int          total = 0;
   int          bad = 0;
   logic        pend_m = 1'b0;
   logic [15:0] hdr_words [4] = '{16'h5548, 16'h4D42, 16'h8800, 16'h8010};
   logic        rq_p = 1'b0;
   logic        busy_p = 1'b0;
   int          hps_st = 0;
   int          hps_cnt = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic push_xfer(input logic is_load);
      for (int k = 0; k < 16; k++)
         exp_q.push_back('{0, is_load, ~is_load, k, 16'd0, is_load, is_load ? pend_m : 1'b0});
      exp_q.push_back('{2, 1'b0, 1'b0, 32'd0, 16'd0, 1'b0, 1'b0});
      pend_m = 1'b0;
   endtask

   task automatic push_fmt();
      for (int k = 0; k < 4; k++)
         exp_q.push_back('{1, 1'b0, 1'b0, k, hdr_words[k], 1'b0, pend_m});
      exp_q.push_back('{2, 1'b0, 1'b0, 32'd0, 16'd0, 1'b0, 1'b1});
      pend_m = 1'b1;
   endtask

   task automatic expect_ev(input int kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_output: kind=%0d rd=%b wr=%b lba=%0d fmt_we=%b (t=%0t)",
                  kind, sd_rd, sd_wr, sd_lba, fmt_we, $time);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", kind, e.kind);
         if (kind == 0) begin
            check("sd_rd", sd_rd, e.rd);
            check("sd_wr", sd_wr, e.wr);
            check("sd_lba", sd_lba, e.addr);
            check("loading_xfer", loading, e.ld);
            check("pending_xfer", pending, e.pd);
            check("busy_xfer", busy, 1'b1);
         end else if (kind == 1) begin
            check("fmt_addr", fmt_addr, e.addr);
            check("fmt_data", fmt_data, e.data);
            check("busy_fmt", busy, 1'b1);
         end else begin
            check("loading_done", loading, 1'b0);
            check("pending_done", pending, e.pd);
         end
      end
   endtask

   task automatic wait_done(input int limit);
      int n = 0;
      while (exp_q.size() != 0 && n < limit) begin
         step();
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL op_timeout: %0d events outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (10) step();
   endtask

   // HPS side: acknowledge each sector request after a random delay, hold ack a random time
   initial begin
      forever begin
         @(posedge clk_sys);
         #1;
         if (!reset_n) begin
            sd_ack = 1'b0;
            hps_st = 0;
         end else begin
            case (hps_st)
               0: if (sd_rd || sd_wr) begin
                     hps_cnt = $urandom_range(0, 3);
                     hps_st = 1;
                  end
               1: if (hps_cnt == 0) begin
                     sd_ack = 1'b1;
                     hps_cnt = $urandom_range(2, 5);
                     hps_st = 2;
                  end else hps_cnt--;
               2: if (hps_cnt == 0) begin
                     sd_ack = 1'b0;
                     hps_st = 3;
                  end else hps_cnt--;
               default: hps_st = 0;
            endcase
         end
      end
   end

   // Monitor: sample on the falling edge and match DUT activity against the queue
   initial begin
      forever begin
         @(negedge clk_sys);
         if (!reset_n) begin
            rq_p = 1'b0;
            busy_p = 1'b0;
         end else begin
            if ((sd_rd || sd_wr) && !rq_p) expect_ev(0);
            if (fmt_we) expect_ev(1);
            if (busy_p && !busy) expect_ev(2);
            rq_p = sd_rd || sd_wr;
            busy_p = busy;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int op, n, sel;
      logic is_load;
      repeat (3) step();
      check("rst_sd_rd", sd_rd, 1'b0);
      check("rst_sd_wr", sd_wr, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_loading", loading, 1'b0);
      check("rst_pending", pending, 1'b0);
      check("rst_fmt_we", fmt_we, 1'b0);
      check("rst_sd_lba", sd_lba, 32'd0);
      reset_n = 1'b1;
      bk_ena = 1'b1;
      repeat (2) step();

      // manual save, then auto-load after download
      push_xfer(1'b0);
      save_req = 1'b1; step(); save_req = 1'b0;
      wait_done(3000);
      push_xfer(1'b1);
      mount_load = 1'b1; step(); mount_load = 1'b0;
      wait_done(3000);

      // autosave on OSD open after a CPU write
      autosave_en = 1'b1;
      bram_wr = 1'b1; step(); bram_wr = 1'b0;
      step();
      check("autosave_pending_set", pending, 1'b1);
      pend_m = 1'b1;
      push_xfer(1'b0);
      osd_open = 1'b1;
      wait_done(3000);
      osd_open = 1'b0;
      autosave_en = 1'b0;
      step();

      // load and save together: load wins; a save edge while busy is dropped
      push_xfer(1'b1);
      load_req = 1'b1; save_req = 1'b1; step(); load_req = 1'b0; save_req = 1'b0;
      repeat (20) step();
      save_req = 1'b1; step(); save_req = 1'b0;
      wait_done(3000);

      // format header
      push_fmt();
      format_req = 1'b1; step(); format_req = 1'b0;
      wait_done(200);
      check("format_pending", pending, 1'b1);

      // reset in the middle of sector 7
      push_xfer(1'b1);
      load_req = 1'b1; step(); load_req = 1'b0;
      n = 0;
      while (!(sd_lba == 32'd7 && busy) && n < 2000) begin
         step();
         n++;
      end
      check("reached_sector7", (sd_lba == 32'd7 && busy), 1'b1);
      #2 reset_n = 1'b0;
      #1;
      check("arst_sd_rd", sd_rd, 1'b0);
      check("arst_sd_wr", sd_wr, 1'b0);
      check("arst_busy", busy, 1'b0);
      check("arst_loading", loading, 1'b0);
      check("arst_sd_lba", sd_lba, 32'd0);
      exp_q.delete();
      pend_m = 1'b0;
      repeat (2) step();
      reset_n = 1'b1;
      step();
      push_xfer(1'b0);
      save_req = 1'b1; step(); save_req = 1'b0;
      wait_done(3000);

      // randomized operation mix
      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 5);
         if (op <= 2) begin
            is_load = (op != 1);
            push_xfer(is_load);
            if (op == 0) begin load_req = 1'b1; step(); load_req = 1'b0; end
            else if (op == 1) begin save_req = 1'b1; step(); save_req = 1'b0; end
            else begin mount_load = 1'b1; step(); mount_load = 1'b0; end
            bk_ena = 1'($urandom_range(0, 1));
            repeat ($urandom_range(3, 40)) step();
            sel = $urandom_range(0, 2);
            if (sel == 0) begin save_req = 1'b1; step(); save_req = 1'b0; end
            else if (sel == 1) begin format_req = 1'b1; step(); format_req = 1'b0; end
            else begin load_req = 1'b1; step(); load_req = 1'b0; end
            wait_done(3000);
            bk_ena = 1'b1;
         end else if (op == 3) begin
            bk_ena = 1'($urandom_range(0, 1));
            push_fmt();
            format_req = 1'b1; step(); format_req = 1'b0;
            wait_done(200);
            bk_ena = 1'b1;
         end else if (op == 4) begin
            bk_ena = 1'b0;
            sel = $urandom_range(0, 2);
            if (sel == 0) begin save_req = 1'b1; step(); save_req = 1'b0; end
            else if (sel == 1) begin load_req = 1'b1; step(); load_req = 1'b0; end
            else begin mount_load = 1'b1; step(); mount_load = 1'b0; end
            repeat (30) step();
            bk_ena = 1'b1;
            check("disabled_idle_busy", busy, 1'b0);
         end else begin
            repeat ($urandom_range(1, 3)) begin
               osd_open = 1'($urandom_range(0, 1));
               bk_ena = 1'($urandom_range(0, 1));
               bram_wr = 1'b1;
               if (bk_ena && !osd_open) pend_m = 1'b1;
               step();
               bram_wr = 1'b0;
            end
            step();
            check("pending_after_writes", pending, pend_m);
            osd_open = 1'b0;
            bk_ena = 1'b1;
            step();
         end
      end

      check("queue_empty_at_end", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
